// File: rtl/button_event_pkg.sv
// Shared FSM states, one-hot event encodings and a width helper for button_event.
// Latency: n/a. Backpressure: n/a.
package button_event_pkg;

  typedef enum logic [1:0] {ARM, IDLE, PRESS, HOLD} btn_state_t;

  // One-hot event vector: {repeat, long, release, press}
  typedef logic [3:0] btn_evt_t;

  localparam btn_evt_t EVT_NONE    = 4'b0000;
  localparam btn_evt_t EVT_PRESS   = 4'b0001;
  localparam btn_evt_t EVT_RELEASE = 4'b0010;
  localparam btn_evt_t EVT_LONG    = 4'b0100;
  localparam btn_evt_t EVT_REPEAT  = 4'b1000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_cycle_timer.sv
// Up-counter with clear, enable and a combinational flag when it sits on the terminal value.
// Latency: tc is combinational from the count register. Backpressure: none; self-wraps at term.
module cycle_timer
  import button_event_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == term);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/button_event.sv
// Turns a debounced level into one-cycle press/release/long/repeat pulses; repeat needs BUTTON_EVENT_AUTO_REPEAT_EN.
// Latency: every output registered, 1 cycle after the clean/en sample that causes it.
// Backpressure: none; pulses are fire-and-forget, en=0 silences everything and re-arms.
module button_event
  import button_event_pkg::*;
#(
  parameter int LONG_CYCLES   = 100_000_000,
  parameter int REPEAT_CYCLES = 20_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clean,
  input  logic en,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam int CNT_W = $clog2(max_int(LONG_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);

  btn_state_t       state;
  btn_evt_t         evt;
  logic             tc;
  logic             timer_clr;
  logic             timer_en;
  logic [CNT_W-1:0] term;

  assign term = (state == HOLD) ? REPEAT_TERM : LONG_TERM;

  // Counter only runs while the button is down; PRESS clears it on the way into HOLD.
  assign timer_clr = !en || !clean || (state == ARM) || (state == IDLE) ||
                     ((state == PRESS) && tc);
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
  assign timer_en = (state == PRESS) || (state == HOLD);
`else
  assign timer_en = (state == PRESS);
`endif

  cycle_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .en   (timer_en),
    .term (term),
    .tc   (tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARM;
      evt   <= EVT_NONE;
      held  <= 1'b0;
    end else begin
      evt <= EVT_NONE;
      if (!en) begin
        state <= ARM;
        held  <= 1'b0;
      end else begin
        case (state)
          ARM: begin
            if (!clean) state <= IDLE;
          end
          IDLE: begin
            if (clean) begin
              state <= PRESS;
              evt   <= EVT_PRESS;
              held  <= 1'b1;
            end
          end
          PRESS: begin
            // Release beats a coincident terminal count.
            if (!clean) begin
              state <= IDLE;
              evt   <= EVT_RELEASE;
              held  <= 1'b0;
            end else if (tc) begin
              state <= HOLD;
              evt   <= EVT_LONG;
            end
          end
          HOLD: begin
            if (!clean) begin
              state <= IDLE;
              evt   <= EVT_RELEASE;
              held  <= 1'b0;
            end
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
            else if (tc) begin
              evt <= EVT_REPEAT;
            end
`endif
          end
          default: begin
            state <= ARM;
            held  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign press_pulse   = |(evt & EVT_PRESS);
  assign release_pulse = |(evt & EVT_RELEASE);
  assign long_pulse    = |(evt & EVT_LONG);
  assign repeat_pulse  = |(evt & EVT_REPEAT);

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench for button_event with LONG_CYCLES=10, REPEAT_CYCLES=4; repeat expectations follow the macro.
module tb_button_event;

  localparam logic [3:0] E_PRESS   = 4'b0001;
  localparam logic [3:0] E_RELEASE = 4'b0010;
  localparam logic [3:0] E_LONG    = 4'b0100;
  localparam logic [3:0] E_REPEAT  = 4'b1000;

  logic clk = 1'b0;
  logic rst;
  logic clean;
  logic en;
  logic press_pulse, release_pulse, long_pulse, repeat_pulse, held;

  button_event #(
    .LONG_CYCLES  (10),
    .REPEAT_CYCLES(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clean        (clean),
    .en           (en),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held)
  );

  always #5 clk = ~clk;

  // Cycle label: outputs changed by posedge n are seen at the following negedge with cyc == n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] code;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic push(input int c, input logic [3:0] code);
    exp_t e;
    e.cyc  = c;
    e.code = code;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every pulse must match the head of the queue in code and cycle.
  logic [3:0] pulses;
  always @(negedge clk) begin
    exp_t e;
    pulses = {repeat_pulse, long_pulse, release_pulse, press_pulse};
    if (rst) begin
      if (pulses != 4'b0000) begin
        if (q.size() == 0) begin
          check("unexpected_evt", {28'd0, pulses}, 32'd0);
        end else begin
          e = q.pop_front();
          check("evt_code", {28'd0, pulses}, {28'd0, e.code});
          check("evt_cycle", cyc, e.cyc);
        end
      end else if (q.size() != 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        check("missing_evt", {28'd0, pulses}, {28'd0, e.code});
      end
    end
  end

  initial begin
    int p;
    rst   = 1'b0;
    en    = 1'b1;
    clean = 1'b1;

    // Reset held with button down, then released: armed, silent.
    step(2);
    check("reset_outs", {27'd0, held, repeat_pulse, long_pulse, release_pulse, press_pulse}, 32'd0);
    rst = 1'b1;
    step(5);
    check("armed_held", {31'd0, held}, 32'd0);
    clean = 1'b0;
    step(3);
    check("arm_release_held", {31'd0, held}, 32'd0);

    // First press + short press of 5 cycles.
    clean = 1'b1;
    push(cyc + 1, E_PRESS);
    step(1);
    check("press_held", {31'd0, held}, 32'd1);
    step(4);
    clean = 1'b0;
    push(cyc + 1, E_RELEASE);
    step(2);
    check("short_rel_held", {31'd0, held}, 32'd0);
    step(3);

    // 30-cycle hold: long at P+10, repeats at P+14..P+26, release at P+30 beats the next repeat.
    clean = 1'b1;
    p = cyc + 1;
    push(p, E_PRESS);
    push(p + 10, E_LONG);
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
    for (int k = 1; k <= 4; k++) push(p + 10 + 4 * k, E_REPEAT);
`endif
    step(15);
    check("hold_held", {31'd0, held}, 32'd1);
    step(15);
    clean = 1'b0;
    push(p + 30, E_RELEASE);
    step(3);
    check("long_rel_held", {31'd0, held}, 32'd0);

    // Release lands exactly on the PRESS terminal count: release only.
    clean = 1'b1;
    p = cyc + 1;
    push(p, E_PRESS);
    step(10);
    clean = 1'b0;
    push(p + 10, E_RELEASE);
    step(2);
    check("tc_rel_held", {31'd0, held}, 32'd0);
    step(12);

    // Asynchronous reset in HOLD, button still down afterwards.
    clean = 1'b1;
    p = cyc + 1;
    push(p, E_PRESS);
    push(p + 10, E_LONG);
    step(12);
    check("pre_rst_held", {31'd0, held}, 32'd1);
    #2 rst = 1'b0;
    #1 check("async_rst_outs", {27'd0, held, repeat_pulse, long_pulse, release_pulse, press_pulse}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step(15);
    check("post_rst_held", {31'd0, held}, 32'd0);
    clean = 1'b0;
    step(2);
    clean = 1'b1;
    push(cyc + 1, E_PRESS);
    step(2);
    check("re_press_held", {31'd0, held}, 32'd1);
    clean = 1'b0;
    push(cyc + 1, E_RELEASE);
    step(3);

    // en dropped mid-PRESS: silent abort, re-armed only by a full release.
    clean = 1'b1;
    push(cyc + 1, E_PRESS);
    step(4);
    en = 1'b0;
    step(1);
    check("en_off_held", {31'd0, held}, 32'd0);
    step(2);
    en = 1'b1;
    step(12);
    check("en_back_held", {31'd0, held}, 32'd0);
    clean = 1'b0;
    step(2);
    clean = 1'b1;
    push(cyc + 1, E_PRESS);
    step(2);
    check("en_repress_held", {31'd0, held}, 32'd1);
    clean = 1'b0;
    push(cyc + 1, E_RELEASE);
    step(5);

    check("queue_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
